// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared types and constants for the ram_loader slice.
//   WORD_W  - width of a Hack RAM word
//   op_e    - command opcodes as carried on cmd_op
//   state_e - sequencer states
package ram_loader_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_loader_addr_ctr.sv
// ram_loader_addr_ctr: wrapping RAM address pointer plus remaining-word count.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   load       - capture base/count (pointer = base, remaining = count)
//   base       - first address of the command
//   count      - number of words, 0..SIZE
//   step       - one word transferred: advance pointer, decrement remaining
//   ptr        - current RAM address
//   last       - remaining == 1, i.e. the current transfer is the final one
module ram_loader_addr_ctr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  logic [ADDR_W:0] remaining;

  // SIZE is a power of two, so natural overflow of ptr is the modulo-SIZE wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= base;
      remaining <= count;
    end else if (step && (remaining != '0)) begin
      ptr       <= ptr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  assign last = (remaining == (ADDR_W+1)'(1));

endmodule

// File: rtl/ram_loader.sv
// ram_loader: command-driven sequencer in front of a Hack RAM block.
// Executes CLEAR (zero-fill), LOAD (stream in) and DUMP (stream out) over a
// wrapping address range, owning the RAM address/in/load pins.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   cmd_valid/ready, cmd_op/base/count  - command handshake and fields
//   s_valid/ready, s_data               - LOAD input stream
//   m_valid/ready, m_data               - DUMP output stream
//   ram_address, ram_in, ram_load       - RAM write/address pins
//   ram_out                             - RAM combinational read data
//   busy, done, error                   - status (done is a one-cycle pulse,
//                                         error is sticky until next accept)
//   checksum                            - only with RAM_LOADER_CHECKSUM_EN:
//                                         mod-2^16 sum of transferred words
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_CLEAR | writing zero, one word per cycle
// S_LOAD  | writing stream words as they arrive
// S_DUMP  | presenting RAM words on the output stream
// S_DONE  | one-cycle completion pulse, then back to idle
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter  int SIZE   = 8,
  localparam int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [WORD_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef RAM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0] SIZE_CNT = (ADDR_W+1)'(SIZE);

  state_e      state;
  op_e         op_in;
  logic        accept;
  logic        bad_cmd;
  logic        empty_cmd;
  logic        ctr_load;
  logic        xfer;
  logic        last;
  logic [ADDR_W-1:0] ptr;

  assign op_in     = op_e'(cmd_op);
  assign accept    = cmd_valid && cmd_ready;
  assign bad_cmd   = (cmd_count > SIZE_CNT) || (op_in == OP_RSVD);
  assign empty_cmd = (cmd_count == '0);
  assign ctr_load  = accept && !bad_cmd && !empty_cmd;

  // One word moves on this edge.
  assign xfer = !reset && ((state == S_CLEAR) ||
                           ((state == S_LOAD) && s_valid) ||
                           ((state == S_DUMP) && m_ready));

  ram_loader_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .base  (cmd_base),
    .count (cmd_count),
    .step  (xfer),
    .ptr   (ptr),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            error <= bad_cmd;
            if (bad_cmd || empty_cmd) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              busy <= 1'b1;
              case (op_in)
                OP_CLEAR: state <= S_CLEAR;
                OP_LOAD:  state <= S_LOAD;
                default:  state <= S_DUMP;
              endcase
            end
          end
        end
        S_CLEAR, S_LOAD, S_DUMP: begin
          if (xfer && last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and write strobes are forced low during reset so nothing
  // transfers or writes in the reset cycle.
  assign cmd_ready   = !reset && (state == S_IDLE);
  assign s_ready     = !reset && (state == S_LOAD);
  assign m_valid     = !reset && (state == S_DUMP);
  assign ram_load    = !reset && ((state == S_CLEAR) || ((state == S_LOAD) && s_valid));
  assign ram_in      = (state == S_LOAD) ? s_data : '0;
  assign ram_address = ptr;
  assign m_data      = ram_out;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] xfer_data;

  always_comb begin
    xfer_data = '0;
    if (state == S_LOAD)      xfer_data = s_data;
    else if (state == S_DUMP) xfer_data = ram_out;
  end

  always_ff @(posedge clk) begin
    if (reset || accept) checksum <= '0;
    else if (xfer)       checksum <= checksum + xfer_data;
  end
`endif

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  localparam int SIZE = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_base = '0;
  logic [3:0]  cmd_count = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [2:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
  logic        busy, done, error;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // RAM attached to the DUT pins, and the bench's own picture of its contents.
  logic [15:0] mem [SIZE];
  logic [15:0] ref_mem [SIZE];
  logic [15:0] load_q [$];

  always #5 clk = ~clk;

  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  ram_loader #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
    .ram_out(ram_out),
    .busy(busy), .done(done), .error(error)
`ifdef RAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_mem();
    for (int k = 0; k < SIZE; k++) check($sformatf("ram[%0d]", k), mem[k], ref_mem[k]);
  endtask

  // Issue one command and follow it to completion, checking every cycle.
  // mask bit (cycle % 32) drives s_valid (LOAD) or m_ready (DUMP).
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] base,
                        input logic [3:0] cnt, input logic [31:0] mask);
    int i = 0;
    int cyc = 0;
    int a;
    bit seen = 0;
    bit bad;
    bit bit_v;
    logic [15:0] sum = '0;
    bad = (op == 2'b11) || (cnt > 4'(SIZE));
    while (load_q.size() < 16) load_q.push_back(16'($urandom));

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_count = cnt;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (done) begin seen = 1; break; end
      check("busy_active", busy, 1);
      check("xfer_within_count", i < int'(cnt), 1);
      if (i >= int'(cnt)) break;
      a = (int'(base) + i) % SIZE;
      bit_v = mask[cyc % 32];
      case (op)
        2'b00: begin
          #1;
          check("clear_load", ram_load, 1);
          check("clear_addr", ram_address, a);
          check("clear_data", ram_in, 0);
          ref_mem[a] = 16'h0000;
          i++;
        end
        2'b01: begin
          s_valid = bit_v;
          s_data  = load_q[i];
          #1;
          check("load_s_ready", s_ready, 1);
          check("load_strobe", ram_load, bit_v);
          check("load_addr", ram_address, a);
          check("load_data", ram_in, load_q[i]);
          if (bit_v) begin
            ref_mem[a] = load_q[i];
            sum += load_q[i];
            i++;
          end
        end
        default: begin
          m_ready = bit_v;
          #1;
          check("dump_m_valid", m_valid, 1);
          check("dump_no_load", ram_load, 0);
          check("dump_addr", ram_address, a);
          check("dump_data", m_data, ref_mem[a]);
          if (bit_v) begin
            sum += ref_mem[a];
            i++;
          end
        end
      endcase
      @(negedge clk);
      s_valid = 1'b0;
      m_ready = 1'b0;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("done_seen", seen, 1);
    if (seen) begin
      #1;
      check("xfer_count", i, bad ? 0 : int'(cnt));
      check("error_flag", error, bad);
      check("done_busy", busy, 0);
      check("done_cmd_ready", cmd_ready, 0);
      check("done_no_load", ram_load, 0);
      if (bad || cnt == 0) check("short_latency", cyc, 1);
      else if (op == 2'b00) check("clear_latency", cyc, int'(cnt) + 1);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("checksum", checksum, sum);
`endif
      @(negedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("back_idle_ready", cmd_ready, 1);
      check("error_sticky", error, bad);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("checksum_hold", checksum, sum);
`endif
    end
    load_q.delete();
  endtask

  initial begin
    for (int k = 0; k < SIZE; k++) begin
      mem[k] = 16'($urandom);
      ref_mem[k] = mem[k];
    end

    repeat (2) @(negedge clk);
    #1;
    check("rst_ram_load", ram_load, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready_after", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_ram_load_after", ram_load, 0);
    check("rst_address", ram_address, 0);
    check("rst_ram_in", ram_in, 0);
    check("rst_s_ready_after", s_ready, 0);
    check("rst_m_valid_after", m_valid, 0);
    check("rst_m_data", m_data, mem[0]);
`ifdef RAM_LOADER_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif

    // Full clear.
    do_cmd(2'b00, 3'd0, 4'd8, 32'hFFFF_FFFF);
    compare_mem();

    // Wrapping load with a two-cycle gap, then read it back.
    load_q = '{16'd11111, 16'd3333, 16'd7777};
    do_cmd(2'b01, 3'd6, 4'd3, 32'hFFFF_FFF9);
    check("wrap_w6", ref_mem[6], 16'd11111);
    compare_mem();
    do_cmd(2'b10, 3'd6, 4'd3, 32'hFFFF_FFFF);

    // Fill, then dump with a stalling consumer.
    do_cmd(2'b01, 3'd0, 4'd8, $urandom | 32'h1111_1111);
    do_cmd(2'b10, 3'd1, 4'd4, 32'h9999_9999);

    // Rejected and empty commands, then a good command clearing error.
    do_cmd(2'b00, 3'd0, 4'd9, 32'hFFFF_FFFF);
    do_cmd(2'b11, 3'd2, 4'd2, 32'hFFFF_FFFF);
    do_cmd(2'b00, 3'd0, 4'd15, 32'hFFFF_FFFF);
    do_cmd(2'b00, 3'd3, 4'd0, 32'hFFFF_FFFF);
    do_cmd(2'b11, 3'd0, 4'd1, 32'hFFFF_FFFF);
    do_cmd(2'b10, 3'd7, 4'd2, $urandom | 32'h1111_1111);
    compare_mem();

    // Reset in the third cycle of an 8-word load.
    begin
      logic [15:0] w [3];
      for (int k = 0; k < 3; k++) w[k] = 16'($urandom);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_base = 3'd0; cmd_count = 4'd8;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        cmd_valid = 1'b0; s_valid = 1'b1; s_data = w[k];
        ref_mem[k] = w[k];
      end
      @(negedge clk);
      reset = 1'b1; s_valid = 1'b1; s_data = w[2];
      #1;
      check("midrst_no_load", ram_load, 0);
      check("midrst_s_ready", s_ready, 0);
      @(negedge clk);
      reset = 1'b0; s_valid = 1'b0;
      #1;
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_addr2", mem[2], ref_mem[2]);
      compare_mem();
    end

    // Random command mix.
    for (int t = 0; t < 12; t++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_cmd(op, 3'($urandom), 4'($urandom_range(0, 9)), $urandom | 32'h1111_1111);
    end
    do_cmd(2'b10, 3'd0, 4'd8, $urandom | 32'h1111_1111);
    compare_mem();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
